bank_ticket_dispatcher: RTL and testbench

//  Parametrised successor of the bank ticket FSM. Serves NUM_SERVICES service queues and NUM_DESKS officer desks.

---
 rtl/bank_ticket_dispatcher.sv | 226 ++++++++++++++++++++++
 tb/tb_bank_ticket_dispatcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_ticket_dispatcher.sv
// bank_ticket_dispatcher
//   Ticket dispatcher for a bank hall. It keeps one queue per service and
//   hands out sequential ticket numbers per service. When a queue is full,
//   the ticket is rejected. When an officer desk calls, the desk gets the
//   oldest ticket of its preferred service. If that service is empty, the
//   other services are searched in order.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   svc_req     one kiosk button per service, sampled every edge
//   desk_call   one "next customer" button per desk, sampled every edge
//   tkt_valid   one-cycle pulse for a ticket event (issued or rejected)
//   tkt_reject  qualifies tkt_valid: the queue was full, no ticket issued
//   tkt_svc     service index of the ticket event
//   tkt_num     issued ticket number
//   tkt_wait    customers already waiting ahead in that service
//   call_valid  one-cycle pulse for a resolved desk call
//   call_none   qualifies call_valid: every queue was empty
//   call_desk   desk being called to
//   call_svc    service of the called ticket
//   call_num    called ticket number
//   wait_cnt    live waiting counts, service s at [s*CNT_W +: CNT_W]

module bank_ticket_dispatcher #(
    parameter int NUM_SERVICES = 3,
    parameter int NUM_DESKS    = 4,
    parameter int QUEUE_DEPTH  = 16,
    parameter int TICKET_W     = 8,
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1),
    localparam int SVC_W  = (NUM_SERVICES > 1) ? $clog2(NUM_SERVICES) : 1,
    localparam int DESK_W = (NUM_DESKS > 1) ? $clog2(NUM_DESKS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SERVICES-1:0]       svc_req,
    input  logic [NUM_DESKS-1:0]          desk_call,
    output logic                          tkt_valid,
    output logic                          tkt_reject,
    output logic [SVC_W-1:0]              tkt_svc,
    output logic [TICKET_W-1:0]           tkt_num,
    output logic [CNT_W-1:0]              tkt_wait,
    output logic                          call_valid,
    output logic                          call_none,
    output logic [DESK_W-1:0]             call_desk,
    output logic [SVC_W-1:0]              call_svc,
    output logic [TICKET_W-1:0]           call_num,
    output logic [NUM_SERVICES*CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CALL
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_SERVICES-1:0]                svc_pend;
    logic [NUM_DESKS-1:0]                   desk_pend;
    logic [NUM_SERVICES-1:0]                svc_clr;
    logic [NUM_DESKS-1:0]                   desk_clr;
    logic [SVC_W-1:0]                       sel_svc;
    logic [DESK_W-1:0]                      sel_desk;
    logic [SVC_W-1:0]                       pick_svc;
    logic [DESK_W-1:0]                      pick_desk;
    logic                                   svc_any;
    logic                                   desk_any;

    logic [NUM_SERVICES-1:0][CNT_W-1:0]     count;
    logic [NUM_SERVICES-1:0][TICKET_W-1:0]  head;
    logic [NUM_SERVICES-1:0][TICKET_W-1:0]  tail;

    logic                                   found;
    logic [SVC_W-1:0]                       found_svc;
    logic [SVC_W-1:0]                       probe;
    int                                     pref;

    assign wait_cnt = count;
    assign svc_any  = |svc_pend;
    assign desk_any = |desk_pend;

    // Lowest-index pending request wins. Scanning downwards lets the last
    // write leave the lowest set index.
    always_comb begin
        pick_svc  = '0;
        pick_desk = '0;
        for (int s = NUM_SERVICES - 1; s >= 0; s--) begin
            if (svc_pend[s]) begin
                pick_svc = SVC_W'(s);
            end
        end
        for (int d = NUM_DESKS - 1; d >= 0; d--) begin
            if (desk_pend[d]) begin
                pick_desk = DESK_W'(d);
            end
        end
    end

    // A pending flag is cleared only when it is selected in IDLE. Ticket
    // requests take priority over desk calls.
    always_comb begin
        svc_clr  = '0;
        desk_clr = '0;
        if (state == IDLE) begin
            if (svc_any) begin
                svc_clr[pick_svc] = 1'b1;
            end else if (desk_any) begin
                desk_clr[pick_desk] = 1'b1;
            end
        end
    end

    // The call search starts at the desk's preferred service and wraps
    // round the other services. It stops at the first non-empty queue.
    always_comb begin
        found     = 1'b0;
        found_svc = '0;
        probe     = '0;
        pref      = int'(sel_desk) % NUM_SERVICES;
        for (int i = 0; i < NUM_SERVICES; i++) begin
            probe = SVC_W'((pref + i) % NUM_SERVICES);
            if (!found && (count[probe] != '0)) begin
                found     = 1'b1;
                found_svc = probe;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ISSUE and CALL each last exactly one cycle.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (svc_any) begin
                    state_next = ISSUE;
                end else if (desk_any) begin
                    state_next = CALL;
                end else begin
                    state_next = IDLE;
                end
            end
            ISSUE:   state_next = IDLE;
            CALL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. On the edge that selects a request, that request's pending
    // flag is cleared. If a new press arrives on the same edge, the press
    // wins, so that press is not lost. Payload outputs hold between events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            svc_pend   <= '0;
            desk_pend  <= '0;
            sel_svc    <= '0;
            sel_desk   <= '0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            tkt_valid  <= 1'b0;
            tkt_reject <= 1'b0;
            tkt_svc    <= '0;
            tkt_num    <= '0;
            tkt_wait   <= '0;
            call_valid <= 1'b0;
            call_none  <= 1'b0;
            call_desk  <= '0;
            call_svc   <= '0;
            call_num   <= '0;
        end else begin
            svc_pend   <= (svc_pend & ~svc_clr) | svc_req;
            desk_pend  <= (desk_pend & ~desk_clr) | desk_call;
            tkt_valid  <= 1'b0;
            call_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (svc_any) begin
                        sel_svc <= pick_svc;
                    end else if (desk_any) begin
                        sel_desk <= pick_desk;
                    end
                end
                ISSUE: begin
                    tkt_valid <= 1'b1;
                    tkt_svc   <= sel_svc;
                    tkt_wait  <= count[sel_svc];
                    if (count[sel_svc] == CNT_W'(QUEUE_DEPTH)) begin
                        tkt_reject <= 1'b1;
                    end else begin
                        tkt_reject     <= 1'b0;
                        tkt_num        <= tail[sel_svc];
                        tail[sel_svc]  <= tail[sel_svc] + TICKET_W'(1);
                        count[sel_svc] <= count[sel_svc] + CNT_W'(1);
                    end
                end
                CALL: begin
                    call_valid <= 1'b1;
                    call_desk  <= sel_desk;
                    if (found) begin
                        call_none        <= 1'b0;
                        call_svc         <= found_svc;
                        call_num         <= head[found_svc];
                        head[found_svc]  <= head[found_svc] + TICKET_W'(1);
                        count[found_svc] <= count[found_svc] - CNT_W'(1);
                    end else begin
                        call_none <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_ticket_dispatcher.sv
// tb_bank_ticket_dispatcher
//   Directed testbench for bank_ticket_dispatcher with its default
//   parameters: 3 services, 4 desks, depth 16 and 8-bit tickets.
//   The bench hand-computes every expected value from the ticket and call
//   history it has driven.

module tb_bank_ticket_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [2:0]  svc_req;
    logic [3:0]  desk_call;
    logic        tkt_valid;
    logic        tkt_reject;
    logic [1:0]  tkt_svc;
    logic [7:0]  tkt_num;
    logic [4:0]  tkt_wait;
    logic        call_valid;
    logic        call_none;
    logic [1:0]  call_desk;
    logic [1:0]  call_svc;
    logic [7:0]  call_num;
    logic [14:0] wait_cnt;

    int errors = 0;
    int checks = 0;

    bank_ticket_dispatcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .svc_req    (svc_req),
        .desk_call  (desk_call),
        .tkt_valid  (tkt_valid),
        .tkt_reject (tkt_reject),
        .tkt_svc    (tkt_svc),
        .tkt_num    (tkt_num),
        .tkt_wait   (tkt_wait),
        .call_valid (call_valid),
        .call_none  (call_none),
        .call_desk  (call_desk),
        .call_svc   (call_svc),
        .call_num   (call_num),
        .wait_cnt   (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside a bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wc(input int s);
        return 32'(wait_cnt[s*5 +: 5]);
    endfunction

    // Hold the buttons for exactly one sampling edge.
    task automatic applyStimulus(input logic [2:0] s, input logic [3:0] d);
        @(negedge clk);
        svc_req   = s;
        desk_call = d;
        @(negedge clk);
        svc_req   = '0;
        desk_call = '0;
    endtask

    // Waits a bounded number of cycles for the next pulse. Every event in
    // this bench is expected exactly two cycles after the previous point.
    task automatic waitEvent(input string tag);
        int  cyc;
        bit  seen;
        cyc  = 99;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (tkt_valid || call_valid) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        checkOutput({tag, "_lat"}, cyc, 2);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issueCheck(input string tag, input int s, input int num, input int waitv);
        applyStimulus(3'(1 << s), 4'b0000);
        waitEvent(tag);
        checkOutput({tag, "_valid"}, tkt_valid, 1);
        checkOutput({tag, "_reject"}, tkt_reject, 0);
        checkOutput({tag, "_svc"}, tkt_svc, s);
        checkOutput({tag, "_num"}, tkt_num, num);
        checkOutput({tag, "_wait"}, tkt_wait, waitv);
    endtask

    task automatic callCheck(input string tag, input int d, input int s, input int num);
        applyStimulus(3'b000, 4'(1 << d));
        waitEvent(tag);
        checkOutput({tag, "_valid"}, call_valid, 1);
        checkOutput({tag, "_none"}, call_none, 0);
        checkOutput({tag, "_desk"}, call_desk, d);
        checkOutput({tag, "_svc"}, call_svc, s);
        checkOutput({tag, "_num"}, call_num, num);
    endtask

    initial begin
        rst_n     = 1'b0;
        svc_req   = '0;
        desk_call = '0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_tkt_valid", tkt_valid, 0);
        checkOutput("rst_tkt_num", tkt_num, 0);
        checkOutput("rst_call_valid", call_valid, 0);
        checkOutput("rst_call_num", call_num, 0);
        checkOutput("rst_wait_cnt", wait_cnt, 0);
        rst_n = 1'b1;

        // First ticket after reset, then the pulse must drop.
        issueCheck("t1", 0, 0, 0);
        checkOutput("t1_wc0", wc(0), 1);
        @(negedge clk);
        checkOutput("t1_pulse", tkt_valid, 0);

        // Three requests in one cycle are served in index order, 2 cycles apart.
        doReset();
        applyStimulus(3'b111, 4'b0000);
        for (int s = 0; s < 3; s++) begin
            waitEvent($sformatf("t2_%0d", s));
            checkOutput($sformatf("t2_svc%0d", s), tkt_svc, s);
            checkOutput($sformatf("t2_num%0d", s), tkt_num, 0);
        end
        checkOutput("t2_wait_cnt", wait_cnt, {5'd1, 5'd1, 5'd1});

        // Fill service 1. The 17th ticket is rejected.
        doReset();
        for (int i = 0; i < 16; i++) begin
            issueCheck($sformatf("t3_fill%0d", i), 1, i, i);
        end
        applyStimulus(3'b010, 4'b0000);
        waitEvent("t3_full");
        checkOutput("t3_full_valid", tkt_valid, 1);
        checkOutput("t3_full_reject", tkt_reject, 1);
        checkOutput("t3_full_wc1", wc(1), 16);
        callCheck("t3_call", 1, 1, 0);
        checkOutput("t3_call_wc1", wc(1), 15);
        issueCheck("t3_after", 1, 16, 15);

        // Fallback search and the empty case.
        doReset();
        issueCheck("t4_a", 2, 0, 0);
        issueCheck("t4_b", 2, 1, 1);
        callCheck("t4_fall", 0, 2, 0);
        checkOutput("t4_fall_wc2", wc(2), 1);
        issueCheck("t4_c", 0, 0, 0);
        callCheck("t4_pref", 3, 0, 0);
        callCheck("t4_last", 1, 2, 1);
        applyStimulus(3'b000, 4'b0010);
        waitEvent("t4_none");
        checkOutput("t4_none_valid", call_valid, 1);
        checkOutput("t4_none_flag", call_none, 1);
        checkOutput("t4_none_svc", call_svc, 2);
        checkOutput("t4_none_num", call_num, 1);
        checkOutput("t4_none_wc", wait_cnt, 0);

        // Ticket and call pressed together: ticket first, call after it.
        applyStimulus(3'b010, 4'b0001);
        waitEvent("t5_tkt");
        checkOutput("t5_tkt_valid", tkt_valid, 1);
        checkOutput("t5_tkt_cv", call_valid, 0);
        checkOutput("t5_tkt_svc", tkt_svc, 1);
        checkOutput("t5_tkt_num", tkt_num, 0);
        waitEvent("t5_call");
        checkOutput("t5_call_valid", call_valid, 1);
        checkOutput("t5_call_tv", tkt_valid, 0);
        checkOutput("t5_call_svc", call_svc, 1);
        checkOutput("t5_call_num", call_num, 0);
        checkOutput("t5_call_wc1", wc(1), 0);

        // Ticket number wrap on service 0.
        doReset();
        for (int i = 0; i < 256; i++) begin
            issueCheck($sformatf("t6_iss%0d", i), 0, i, 0);
            callCheck($sformatf("t6_call%0d", i), 0, 0, i);
        end
        issueCheck("t6_wrap", 0, 0, 0);

        // Asynchronous reset mid-stream discards queues and pending flags.
        applyStimulus(3'b111, 4'b0000);
        waitEvent("t7_pre");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_async_num", tkt_num, 0);
        checkOutput("t7_async_svc", tkt_svc, 0);
        checkOutput("t7_async_wc", wait_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issueCheck("t7_post", 2, 0, 0);
        checkOutput("t7_post_wc", wait_cnt, {5'd1, 5'd0, 5'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
